// File: rtl/btn_pkg.sv
// Shared definitions for the set-mode button conditioner.
// Contents: the per-channel FSM state type, the button channel indices, the
// default timing constants, and a helper that sizes the shared counter.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    DEB_REL   = 3'd4
  } btn_state_e;

  // Channel indices into btn_in / btn_level / btn_pulse
  localparam int unsigned BTN_INC_HR  = 0;
  localparam int unsigned BTN_INC_MIN = 1;
  localparam int unsigned BTN_DEC_HR  = 2;
  localparam int unsigned BTN_DEC_MIN = 3;

  // Defaults sized for a 100 MHz Gclk
  localparam int unsigned DEF_NBTN       = 4;
  localparam int unsigned DEF_DEB_CYCLES = 1000000;
  localparam int unsigned DEF_RPT_DELAY  = 50000000;
  localparam int unsigned DEF_RPT_PERIOD = 20000000;

  // Largest of three timing values; used to size the per-channel counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single button channel: 2-flop synchroniser, debounce / auto-repeat FSM and
// its shared counter.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   btn_i    raw asynchronous button level
//   level_o  debounced level (registered)
//   event_o  one-cycle press / repeat event (registered)
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic event_o
);

  localparam int unsigned CW = $clog2(max3(DEB_CYCLES, RPT_DELAY, RPT_PERIOD)) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD - 1);

  logic [1:0]    sync_q;
  logic          s_c;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          event_q, event_d;

  // Synchroniser; the FSM only looks at the second stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], btn_i};
  end

  assign s_c = sync_q[1];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      event_q <= event_d;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    event_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_c) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          event_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s_c) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          state_d = REPEAT;
          event_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!s_c) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          event_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DEB_REL: begin
        // A bounce back high restarts the full repeat delay without an event
        if (s_c) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o = level_q;
  assign event_o = event_q;

endmodule

// File: rtl/btn_cond.sv
// Set-mode push-button conditioner: per-channel debounce with auto-repeat,
// pending flags, and a fixed-priority arbiter that emits at most one pulse
// per cycle (lowest index wins).
// Ports:
//   Gclk       system clock
//   rst_n      asynchronous active-low reset
//   enable     set mode active; when low, pending events are dropped
//   btn_in     raw asynchronous button levels, active high
//   btn_level  debounced level per button (registered)
//   btn_pulse  one-hot or zero, one-cycle event pulses (registered)
module btn_cond
  import btn_pkg::*;
#(
  parameter int unsigned NBTN       = DEF_NBTN,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic            Gclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse
);

  logic [NBTN-1:0] level_c, event_c, grant_c;
  logic [NBTN-1:0] pend_q, pend_d;
  logic [NBTN-1:0] pulse_q, pulse_d;
  logic [NBTN-1:0] level_q;

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
    ) u_deb (
      .clk_i   (Gclk),
      .rst_ni  (rst_n),
      .btn_i   (btn_in[g]),
      .level_o (level_c[g]),
      .event_o (event_c[g])
    );
  end

  // Lowest set pending bit wins; an event landing on the granted channel
  // re-arms its flag so it is not lost.
  always_comb begin
    grant_c = pend_q & (~pend_q + NBTN'(1));
    pend_d  = '0;
    pulse_d = '0;
    if (enable) begin
      pend_d  = (pend_q & ~grant_c) | event_c;
      pulse_d = grant_c;
    end
  end

  always_ff @(posedge Gclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      pulse_q <= '0;
      level_q <= '0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      level_q <= level_c;
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with short timing: DEB_CYCLES=4, RPT_DELAY=10,
// RPT_PERIOD=5. Cycle index i counts posedges from the first edge that
// samples the new btn_in value; outputs are sampled 1 ns after each edge.
module tb_btn_cond;
  import btn_pkg::*;

  localparam int unsigned NBTN = 4;

  logic            Gclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [NBTN-1:0] btn_in = '0;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_pulse;

  int errors = 0;
  int checks = 0;

  always #5 Gclk = ~Gclk;

  btn_cond #(
    .NBTN       (NBTN),
    .DEB_CYCLES (4),
    .RPT_DELAY  (10),
    .RPT_PERIOD (5)
  ) dut (
    .Gclk      (Gclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  task automatic tick();
    @(posedge Gclk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    btn_in = '0;
    settle(3);
    checks++;
    if (btn_level !== 4'b0000) begin
      errors++;
      $display("FAIL reset_level: got %b expected %b", btn_level, 4'b0000);
    end
    checks++;
    if (btn_pulse !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulse: got %b expected %b", btn_pulse, 4'b0000);
    end
    rst_n = 1'b1;
    settle(3);
  endtask

  // Tap inc_hr for 12 sampled cycles: one pulse at 8, level 7..18
  task automatic test_clean_tap();
    logic [3:0] ep, el;
    btn_in[BTN_INC_HR] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 11) btn_in = '0;
      ep = (i == 8) ? 4'b0001 : 4'b0000;
      el = (i >= 7 && i <= 18) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_pulse !== ep) begin
        errors++;
        $display("FAIL tap_pulse cyc=%0d: got %b expected %b", i, btn_pulse, ep);
      end
      checks++;
      if (btn_level !== el) begin
        errors++;
        $display("FAIL tap_level cyc=%0d: got %b expected %b", i, btn_level, el);
      end
    end
    settle(10);
  endtask

  // inc_min bounces 1,0,1,0 then stays high from cycle 4 to 13
  task automatic test_bounce();
    logic [3:0] ep, el;
    btn_in[BTN_INC_MIN] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 0 || i == 2 || i == 13) btn_in[BTN_INC_MIN] = 1'b0;
      if (i == 1 || i == 3)            btn_in[BTN_INC_MIN] = 1'b1;
      ep = (i == 12) ? 4'b0010 : 4'b0000;
      el = (i >= 11 && i <= 20) ? 4'b0010 : 4'b0000;
      checks++;
      if (btn_pulse !== ep) begin
        errors++;
        $display("FAIL bounce_pulse cyc=%0d: got %b expected %b", i, btn_pulse, ep);
      end
      checks++;
      if (btn_level !== el) begin
        errors++;
        $display("FAIL bounce_level cyc=%0d: got %b expected %b", i, btn_level, el);
      end
    end
    settle(10);
  endtask

  // 3-cycle high glitch on dec_hr: nothing observable
  task automatic test_glitch();
    btn_in[BTN_DEC_HR] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 2) btn_in = '0;
      checks++;
      if (btn_pulse !== 4'b0000 || btn_level !== 4'b0000) begin
        errors++;
        $display("FAIL glitch cyc=%0d: got pulse=%b level=%b expected 0000/0000",
                 i, btn_pulse, btn_level);
      end
    end
    settle(5);
  endtask

  // Hold inc_min for 39 sampled cycles: pulses 8,18,23,28,33,38
  task automatic test_hold();
    logic [3:0] ep, el;
    btn_in[BTN_INC_MIN] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 38) btn_in = '0;
      ep = (i == 8 || i == 18 || i == 23 || i == 28 || i == 33 || i == 38)
           ? 4'b0010 : 4'b0000;
      el = (i >= 7 && i <= 45) ? 4'b0010 : 4'b0000;
      checks++;
      if (btn_pulse !== ep) begin
        errors++;
        $display("FAIL hold_pulse cyc=%0d: got %b expected %b", i, btn_pulse, ep);
      end
      checks++;
      if (btn_level !== el) begin
        errors++;
        $display("FAIL hold_level cyc=%0d: got %b expected %b", i, btn_level, el);
      end
    end
    settle(5);
  endtask

  // inc_hr and dec_min together: bit 0 first, bit 3 on the next cycle
  task automatic test_simultaneous();
    logic [3:0] ep, el;
    btn_in[BTN_INC_HR]  = 1'b1;
    btn_in[BTN_DEC_MIN] = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (i == 11) btn_in = '0;
      ep = (i == 8) ? 4'b0001 : (i == 9) ? 4'b1000 : 4'b0000;
      el = (i >= 7 && i <= 18) ? 4'b1001 : 4'b0000;
      checks++;
      if (btn_pulse !== ep) begin
        errors++;
        $display("FAIL simul_pulse cyc=%0d: got %b expected %b", i, btn_pulse, ep);
      end
      checks++;
      if (btn_level !== el) begin
        errors++;
        $display("FAIL simul_level cyc=%0d: got %b expected %b", i, btn_level, el);
      end
    end
    settle(10);
  endtask

  // dec_hr held with enable low; enable rises after cycle 17 so the
  // repeat events at 16 is dropped and those at 21, 26 pulse at 23, 28
  task automatic test_enable_gating();
    logic [3:0] ep, el;
    enable = 1'b0;
    btn_in[BTN_DEC_HR] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 17) enable = 1'b1;
      ep = (i == 23 || i == 28) ? 4'b0100 : 4'b0000;
      el = (i >= 7) ? 4'b0100 : 4'b0000;
      checks++;
      if (btn_pulse !== ep) begin
        errors++;
        $display("FAIL enable_pulse cyc=%0d: got %b expected %b", i, btn_pulse, ep);
      end
      checks++;
      if (btn_level !== el) begin
        errors++;
        $display("FAIL enable_level cyc=%0d: got %b expected %b", i, btn_level, el);
      end
    end
    btn_in = '0;
    settle(20);
  endtask

  // Reset while inc_hr repeats; the press restarts from scratch afterwards
  task automatic test_reset_mid_hold();
    logic [3:0] ep, el;
    btn_in[BTN_INC_HR] = 1'b1;
    settle(19);
    checks++;
    if (btn_pulse !== 4'b0001 || btn_level !== 4'b0001) begin
      errors++;
      $display("FAIL rst_pre: got pulse=%b level=%b expected 0001/0001",
               btn_pulse, btn_level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (btn_pulse !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async_pulse: got %b expected %b", btn_pulse, 4'b0000);
    end
    checks++;
    if (btn_level !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async_level: got %b expected %b", btn_level, 4'b0000);
    end
    settle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      ep = (i == 8) ? 4'b0001 : 4'b0000;
      el = (i >= 7) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_pulse !== ep) begin
        errors++;
        $display("FAIL rst_repress_pulse cyc=%0d: got %b expected %b", i, btn_pulse, ep);
      end
      checks++;
      if (btn_level !== el) begin
        errors++;
        $display("FAIL rst_repress_level cyc=%0d: got %b expected %b", i, btn_level, el);
      end
    end
    btn_in = '0;
    settle(20);
  endtask

  initial begin
    test_reset();
    test_clean_tap();
    test_bounce();
    test_glitch();
    test_hold();
    test_simultaneous();
    test_enable_gating();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
